cache_port_arbiter: RTL

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

---
 rtl/cache_port_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cache_port_arbiter.sv
// Two-requester cache port arbiter with flush sequencing (IDLE/BUSY/FLUSH).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to r0.
module cache_port_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic              r0_rw,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ready,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    input  logic              r1_rw,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ready,
    output logic [DATA_W-1:0] r1_rdata,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              cache_valid,
    output logic              cache_rw,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wr,
    output logic              flush,
    input  logic [DATA_W-1:0] cache_rd,
    input  logic              cache_ready,
    output logic              grant_id,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

    state_t            state_q, state_d;
    logic              cache_valid_q, cache_valid_d;
    logic              cache_rw_q, cache_rw_d;
    logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
    logic [DATA_W-1:0] cache_wr_q, cache_wr_d;
    logic              flush_q, flush_d;
    logic              grant_id_q, grant_id_d;
    logic              busy_q, busy_d;
    logic              win_id;
`ifdef ARB_ROUND_ROBIN_EN
    logic              rr_last_q, rr_last_d;
`endif

    // Pick the winner among currently valid requesters.
    always_comb begin : arbitrate
`ifdef ARB_ROUND_ROBIN_EN
        if (r0_valid && r1_valid) begin
            win_id = ~rr_last_q;
        end else begin
            win_id = ~r0_valid;
        end
`else
        win_id = ~r0_valid;
`endif
    end

    always_comb begin : next_state
        state_d       = state_q;
        cache_valid_d = cache_valid_q;
        cache_rw_d    = cache_rw_q;
        cache_addr_d  = cache_addr_q;
        cache_wr_d    = cache_wr_q;
        flush_d       = flush_q;
        grant_id_d    = grant_id_q;
        busy_d        = busy_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_last_d     = rr_last_q;
`endif
        case (state_q)
            IDLE: begin
                // Flush outranks both requesters.
                if (flush_req) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (r0_valid || r1_valid) begin
                    state_d       = BUSY;
                    cache_valid_d = 1'b1;
                    busy_d        = 1'b1;
                    grant_id_d    = win_id;
                    cache_rw_d    = win_id ? r1_rw    : r0_rw;
                    cache_addr_d  = win_id ? r1_addr  : r0_addr;
                    cache_wr_d    = win_id ? r1_wdata : r0_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_last_d     = win_id;
`endif
                end
            end
            BUSY: begin
                if (cache_ready) begin
                    state_d       = IDLE;
                    cache_valid_d = 1'b0;
                    busy_d        = 1'b0;
                end
            end
            FLUSH: begin
                if (cache_ready) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d       = IDLE;
                cache_valid_d = 1'b0;
                flush_d       = 1'b0;
                busy_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cache_valid_q <= 1'b0;
            cache_rw_q    <= 1'b0;
            cache_addr_q  <= '0;
            cache_wr_q    <= '0;
            flush_q       <= 1'b0;
            grant_id_q    <= 1'b0;
            busy_q        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q     <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            cache_valid_q <= cache_valid_d;
            cache_rw_q    <= cache_rw_d;
            cache_addr_q  <= cache_addr_d;
            cache_wr_q    <= cache_wr_d;
            flush_q       <= flush_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q     <= rr_last_d;
`endif
        end
    end

    // Completion pulses follow cache_ready in the same cycle; only the owner sees it.
    assign r0_ready   = (state_q == BUSY)  && cache_ready && !grant_id_q;
    assign r1_ready   = (state_q == BUSY)  && cache_ready &&  grant_id_q;
    assign flush_done = (state_q == FLUSH) && cache_ready;
    assign r0_rdata   = cache_rd;
    assign r1_rdata   = cache_rd;

    assign cache_valid = cache_valid_q;
    assign cache_rw    = cache_rw_q;
    assign cache_addr  = cache_addr_q;
    assign cache_wr    = cache_wr_q;
    assign flush       = flush_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;

endmodule
